// File: rtl/dark_pkg.sv
// Shared definitions for the dark-frame inverting mixer.
//   - Luma weights and shift: luma = (2R + 5G + B) >> 3
//   - mode_i encodings (auto / force off / force on / auto)
//   - Frame-brightness state enum
//   - luma8(): 8-bit luma of a packed R[23:16] G[15:8] B[7:0] pixel
package dark_pkg;

    localparam int unsigned LUMA_WR    = 2;
    localparam int unsigned LUMA_WG    = 5;
    localparam int unsigned LUMA_WB    = 1;
    localparam int unsigned LUMA_SHIFT = 3;

    localparam logic [1:0] MODE_AUTO     = 2'b00;
    localparam logic [1:0] MODE_OFF      = 2'b01;
    localparam logic [1:0] MODE_ON       = 2'b10;
    localparam logic [1:0] MODE_AUTO_ALT = 2'b11;

    typedef enum logic {
        ST_NORMAL   = 1'b0,
        ST_INVERTED = 1'b1
    } state_e;

    // Weighted sum peaks at 8*255 = 2040, so 11 bits hold it exactly.
    function automatic logic [7:0] luma8(input logic [23:0] px);
        logic [10:0] acc;
        acc = 11'(LUMA_WR * 32'(px[23:16]) + LUMA_WG * 32'(px[15:8]) + LUMA_WB * 32'(px[7:0]));
        return 8'(acc >> LUMA_SHIFT);
    endfunction

endpackage

// File: rtl/dark_stats.sv
// Per-frame luma statistics and the NORMAL/INVERTED hysteresis machine.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   vs_i, de_i      vertical sync and data enable of the live stream
//   live_i          current-frame pixel (R[23:16] G[15:8] B[7:0])
//   state_o         current brightness state
//   ferr_o          last completed frame had the wrong pixel count
module dark_stats
    import dark_pkg::*;
#(
    parameter int unsigned H_WIDTH  = 1920,
    parameter int unsigned V_HEIGHT = 1080,
    parameter int unsigned HI_MEAN  = 128,
    parameter int unsigned LO_MEAN  = 96
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        vs_i,
    input  logic        de_i,
    input  logic [23:0] live_i,
    output state_e      state_o,
    output logic        ferr_o
);

    // Thresholds are scaled to whole-frame sums so no divide or runtime multiply is needed.
    localparam logic [63:0] FRAME_PIX = 64'(H_WIDTH) * 64'(V_HEIGHT);
    localparam logic [63:0] HI_LIMIT  = 64'(HI_MEAN) * FRAME_PIX;
    localparam logic [63:0] LO_LIMIT  = 64'(LO_MEAN) * FRAME_PIX;

    logic [7:0]  luma;
    logic        vs_r_q;
    logic        vs_rise;
    logic [31:0] sum_q, sum_d;
    logic [32:0] sum_wide;
    logic [21:0] pcnt_q, pcnt_d;
    logic        frame_ok;
    logic        ferr_q;
    state_e      state_q, state_d;

    assign luma     = luma8(live_i);
    assign vs_rise  = vs_i & ~vs_r_q;
    assign frame_ok = (64'(pcnt_q) == FRAME_PIX);

    // Accumulator and pixel counter; a vs rise restarts both, counting a pixel
    // that happens to coincide with the rise as the first of the new frame.
    always_comb begin
        sum_wide = {1'b0, sum_q} + {25'd0, luma};
        sum_d    = sum_q;
        pcnt_d   = pcnt_q;
        if (vs_rise) begin
            sum_d  = de_i ? {24'd0, luma} : 32'd0;
            pcnt_d = de_i ? 22'd1 : 22'd0;
        end else if (de_i) begin
            sum_d  = sum_wide[32] ? '1 : sum_wide[31:0];
            pcnt_d = (&pcnt_q) ? pcnt_q : pcnt_q + 22'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vs_r_q <= 1'b0;
            sum_q  <= '0;
            pcnt_q <= '0;
            ferr_q <= 1'b0;
        end else begin
            vs_r_q <= vs_i;
            sum_q  <= sum_d;
            pcnt_q <= pcnt_d;
            if (vs_rise) begin
                ferr_q <= ~frame_ok;
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: decided on the statistics of the frame just ended, and only
    // when that frame had exactly the expected number of pixels.
    always_comb begin
        state_d = state_q;
        if (vs_rise && frame_ok) begin
            case (state_q)
                ST_NORMAL:   if (64'(sum_q) > HI_LIMIT) state_d = ST_INVERTED;
                ST_INVERTED: if (64'(sum_q) < LO_LIMIT) state_d = ST_NORMAL;
                default:     state_d = ST_NORMAL;
            endcase
        end
    end

    // Outputs
    always_comb begin
        state_o = state_q;
        ferr_o  = ferr_q;
    end

endmodule

// File: rtl/dark_mixer.sv
// Dark-frame mixer: passes the one-frame-delayed stream through a two-stage
// pipeline, colour-inverting it when the live stream's mean luma is bright
// (with hysteresis) or when forced by mode_i.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   mode_i                 00/11 auto, 01 force off, 10 force on
//   vs_i, hs_i, de_i       input sync / data enable
//   live_i                 current-frame pixel (statistics source)
//   dly_i                  delayed pixel (output source), aligned with de_i
//   vs_o, hs_o, de_o       sync / enable delayed by two cycles
//   data_o                 output pixel, zero outside active video
//   inv_o                  inversion active
//   ferr_o                 last frame malformed
module dark_mixer
    import dark_pkg::*;
#(
    parameter int unsigned H_WIDTH  = 1920,
    parameter int unsigned V_HEIGHT = 1080,
    parameter int unsigned HI_MEAN  = 128,
    parameter int unsigned LO_MEAN  = 96
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  mode_i,
    input  logic        vs_i,
    input  logic        hs_i,
    input  logic        de_i,
    input  logic [23:0] live_i,
    input  logic [23:0] dly_i,
    output logic        vs_o,
    output logic        hs_o,
    output logic        de_o,
    output logic [23:0] data_o,
    output logic        inv_o,
    output logic        ferr_o
);

    state_e      stat_state;
    logic        stat_ferr;
    logic        inv_d, inv_q;
    logic [23:0] s1_data_q;
    logic        s1_vs_q, s1_hs_q, s1_de_q;
    logic [23:0] data_d, data_q;
    logic        vs_q, hs_q, de_q;

    dark_stats #(
        .H_WIDTH  (H_WIDTH),
        .V_HEIGHT (V_HEIGHT),
        .HI_MEAN  (HI_MEAN),
        .LO_MEAN  (LO_MEAN)
    ) u_stats (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .vs_i    (vs_i),
        .de_i    (de_i),
        .live_i  (live_i),
        .state_o (stat_state),
        .ferr_o  (stat_ferr)
    );

    // The machine keeps running under forced modes, so returning to auto
    // picks up its current state on the next cycle.
    always_comb begin
        case (mode_i)
            MODE_OFF: inv_d = 1'b0;
            MODE_ON:  inv_d = 1'b1;
            default:  inv_d = (stat_state == ST_INVERTED);
        endcase
    end

    always_comb begin
        data_d = '0;
        if (s1_de_q) begin
            data_d = inv_q ? ~s1_data_q : s1_data_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inv_q     <= 1'b0;
            s1_data_q <= '0;
            s1_vs_q   <= 1'b0;
            s1_hs_q   <= 1'b0;
            s1_de_q   <= 1'b0;
            data_q    <= '0;
            vs_q      <= 1'b0;
            hs_q      <= 1'b0;
            de_q      <= 1'b0;
        end else begin
            inv_q     <= inv_d;
            s1_data_q <= dly_i;
            s1_vs_q   <= vs_i;
            s1_hs_q   <= hs_i;
            s1_de_q   <= de_i;
            data_q    <= data_d;
            vs_q      <= s1_vs_q;
            hs_q      <= s1_hs_q;
            de_q      <= s1_de_q;
        end
    end

    assign vs_o   = vs_q;
    assign hs_o   = hs_q;
    assign de_o   = de_q;
    assign data_o = data_q;
    assign inv_o  = inv_q;
    assign ferr_o = stat_ferr;

endmodule

// File: tb/tb_dark_mixer.sv
module tb_dark_mixer;

    logic        clk_i  = 1'b0;
    logic        rst_ni = 1'b1;
    logic [1:0]  mode_i = 2'b00;
    logic        vs_i   = 1'b0;
    logic        hs_i   = 1'b0;
    logic        de_i   = 1'b0;
    logic [23:0] live_i = '0;
    logic [23:0] dly_i  = '0;
    logic        vs_o, hs_o, de_o, inv_o, ferr_o;
    logic [23:0] data_o;

    int checks = 0;
    int errors = 0;

    logic [23:0] exp_q[$];
    logic        exp_inv = 1'b0;
    logic [2:0]  sync_h1, sync_h2;

    dark_mixer #(
        .H_WIDTH  (4),
        .V_HEIGHT (2),
        .HI_MEAN  (128),
        .LO_MEAN  (96)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .mode_i (mode_i),
        .vs_i   (vs_i),
        .hs_i   (hs_i),
        .de_i   (de_i),
        .live_i (live_i),
        .dly_i  (dly_i),
        .vs_o   (vs_o),
        .hs_o   (hs_o),
        .de_o   (de_o),
        .data_o (data_o),
        .inv_o  (inv_o),
        .ferr_o (ferr_o)
    );

    always #5 clk_i = ~clk_i;

    // Two-cycle delay line of the driven sync inputs.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_h1 <= '0;
            sync_h2 <= '0;
        end else begin
            sync_h1 <= {vs_i, hs_i, de_i};
            sync_h2 <= sync_h1;
        end
    end

    // Monitor: sync timing every cycle, pixel scoreboard whenever de_o is high.
    always @(negedge clk_i) begin
        logic [23:0] e;
        checks++;
        if ({vs_o, hs_o, de_o} !== sync_h2) begin
            errors++;
            $display("FAIL sync_delay: got %b required %b", {vs_o, hs_o, de_o}, sync_h2);
        end
        checks++;
        if (de_o) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL data_unexpected: got %06h required no pixel", data_o);
            end else begin
                e = exp_q.pop_front();
                if (data_o !== e) begin
                    errors++;
                    $display("FAIL data: got %06h required %06h", data_o, e);
                end else begin
                    $display("pixel out %06h (expected %06h)", data_o, e);
                end
            end
        end else if (data_o !== 24'd0) begin
            errors++;
            $display("FAIL data_blank: got %06h required 000000", data_o);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [23:0] got, input logic [23:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end else begin
            $display("check %s = %0h", name, got);
        end
    endtask

    task automatic vsync();
        vs_i = 1'b1;
        tick();
        vs_i = 1'b0;
        tick();
    endtask

    task automatic set_mode(input logic [1:0] m);
        mode_i = m;
        tick();
        tick();
    endtask

    task automatic send_frame(input int n, input logic [23:0] live, input logic [23:0] dly);
        hs_i = 1'b1;
        tick();
        hs_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            de_i   = 1'b1;
            live_i = live;
            dly_i  = dly;
            exp_q.push_back(exp_inv ? ~dly : dly);
            tick();
        end
        de_i   = 1'b0;
        live_i = '0;
        dly_i  = '0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        // Reset state
        #1 rst_ni = 1'b0;
        #2;
        chk("rst_inv", {23'd0, inv_o}, 24'd0);
        chk("rst_ferr", {23'd0, ferr_o}, 24'd0);
        chk("rst_data", data_o, 24'd0);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        // First vs rise after reset sees an empty frame
        vsync();
        chk("first_vs_ferr", {23'd0, ferr_o}, 24'd1);
        chk("first_vs_inv", {23'd0, inv_o}, 24'd0);

        // Bright frame: 8*255 = 2040 > 1024 -> INVERTED
        send_frame(8, 24'hFFFFFF, 24'h000001);
        vsync();
        exp_inv = 1'b1;
        chk("bright_inv", {23'd0, inv_o}, 24'd1);
        chk("bright_ferr", {23'd0, ferr_o}, 24'd0);

        // Luma 100: sum 800, hold INVERTED; 0x123456 comes out as 0xEDCBA9
        send_frame(8, 24'h646464, 24'h123456);
        vsync();
        chk("hold_inv", {23'd0, inv_o}, 24'd1);

        // Luma 90: sum 720 < 768 -> NORMAL
        send_frame(8, 24'h5A5A5A, 24'hABCDEF);
        vsync();
        exp_inv = 1'b0;
        chk("release_inv", {23'd0, inv_o}, 24'd0);

        // Short bright frame: error flagged, state held
        send_frame(7, 24'hFFFFFF, 24'h0F0F0F);
        vsync();
        chk("short_ferr", {23'd0, ferr_o}, 24'd1);
        chk("short_inv", {23'd0, inv_o}, 24'd0);
        send_frame(8, 24'h5A5A5A, 24'h010203);
        vsync();
        chk("full_ferr", {23'd0, ferr_o}, 24'd0);
        chk("full_inv", {23'd0, inv_o}, 24'd0);

        // Forced on while NORMAL, then back to auto
        set_mode(2'b10);
        exp_inv = 1'b1;
        chk("force_on_inv", {23'd0, inv_o}, 24'd1);
        send_frame(8, 24'h646464, 24'h00FF00);
        vsync();
        chk("force_on_hold", {23'd0, inv_o}, 24'd1);
        set_mode(2'b00);
        exp_inv = 1'b0;
        chk("auto_normal_inv", {23'd0, inv_o}, 24'd0);

        // Reach INVERTED, then force off; machine keeps tracking
        send_frame(8, 24'hFFFFFF, 24'h000000);
        vsync();
        exp_inv = 1'b1;
        chk("reinvert_inv", {23'd0, inv_o}, 24'd1);
        set_mode(2'b01);
        exp_inv = 1'b0;
        chk("force_off_inv", {23'd0, inv_o}, 24'd0);
        send_frame(8, 24'h5A5A5A, 24'h445566);
        vsync();
        set_mode(2'b00);
        chk("tracked_normal_inv", {23'd0, inv_o}, 24'd0);
        set_mode(2'b01);
        send_frame(8, 24'hFFFFFF, 24'h778899);
        vsync();
        chk("forced_off_bright_inv", {23'd0, inv_o}, 24'd0);
        set_mode(2'b11);
        exp_inv = 1'b1;
        chk("tracked_inverted_inv", {23'd0, inv_o}, 24'd1);

        // Random sync pattern; luma 128 keeps the state fixed whatever frame lengths occur
        for (int i = 0; i < 80; i++) begin
            vs_i   = ($urandom_range(0, 7) == 0);
            hs_i   = $urandom_range(0, 1) == 1;
            de_i   = $urandom_range(0, 1) == 1;
            live_i = 24'h808080;
            dly_i  = 24'($urandom);
            if (de_i) exp_q.push_back(exp_inv ? ~dly_i : dly_i);
            tick();
        end
        vs_i = 1'b0; hs_i = 1'b0; de_i = 1'b0; live_i = '0; dly_i = '0;
        tick();
        tick();
        tick();
        chk("random_inv", {23'd0, inv_o}, 24'd1);

        // Reset mid-frame while INVERTED
        de_i   = 1'b1;
        live_i = 24'hFFFFFF;
        dly_i  = 24'h111111;
        tick();
        rst_ni = 1'b0;
        de_i   = 1'b0;
        live_i = '0;
        dly_i  = '0;
        #1;
        chk("midrst_inv", {23'd0, inv_o}, 24'd0);
        chk("midrst_ferr", {23'd0, ferr_o}, 24'd0);
        chk("midrst_sync", {21'd0, vs_o, hs_o, de_o}, 24'd0);
        chk("midrst_data", data_o, 24'd0);
        exp_inv = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        send_frame(5, 24'hFFFFFF, 24'h222222);
        vsync();
        chk("post_rst_ferr", {23'd0, ferr_o}, 24'd1);
        chk("post_rst_inv", {23'd0, inv_o}, 24'd0);

        tick();
        tick();
        chk("scoreboard_empty", 24'(exp_q.size()), 24'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
